// File: rtl/rom_burst_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : rom_burst_reader_if
// Purpose  : Bundles the command, ROM-side and stream-side signals of
//            rom_burst_reader.
//            master -> the reader itself (drives rom_addr and the stream)
//            slave  -> the surrounding logic (command source, ROM, consumer)
// Signals  : start/base_addr/burst_len  burst command
//            busy/done                  command status
//            rom_addr/rom_data          ROM address out, ROM data in
//            out_valid/out_ready        stream handshake
//            out_data/out_addr          stream payload and its source address
// Revision : 1.0 - initial release
// ============================================================================
interface rom_burst_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]  burst_len;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_addr;

  modport master (
    input  start, base_addr, burst_len, rom_data, out_ready,
    output busy, done, rom_addr, out_valid, out_data, out_addr
  );

  modport slave (
    output start, base_addr, burst_len, rom_data, out_ready,
    input  busy, done, rom_addr, out_valid, out_data, out_addr
  );
endinterface
`default_nettype wire

// File: rtl/rom_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : rom_burst_reader
// Purpose  : Address sequencer for a combinational ROM. A start command
//            fetches burst_len consecutive words from base_addr (wrapping at
//            the top of the address space) and presents them as a
//            valid/ready stream with full backpressure.
// Ports    : clk  - single clock, rising edge
//            rst  - synchronous, active-high reset
//            bus  - rom_burst_reader_if.master (command, ROM, stream signals)
// Revision : 1.0 - initial release
// ============================================================================
module rom_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  wire logic            clk,
  input  wire logic            rst,
  rom_burst_reader_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                r_state,     w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_rom_addr,  w_rom_addr_nxt;
  logic [LEN_WIDTH-1:0]  r_remaining, w_remaining_nxt;
  logic                  r_out_valid, w_out_valid_nxt;
  logic [DATA_WIDTH-1:0] r_out_data,  w_out_data_nxt;
  logic [ADDR_WIDTH-1:0] r_out_addr,  w_out_addr_nxt;
  logic                  r_busy,      w_busy_nxt;
  logic                  r_done,      w_done_nxt;

  // The output register may be refilled when it is empty or is being
  // emptied this cycle; this gives one beat per cycle with no bubble.
  logic w_load;
  assign w_load = !r_out_valid || bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rom_addr  <= '0;
      r_remaining <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rom_addr  <= w_rom_addr_nxt;
      r_remaining <= w_remaining_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_addr  <= w_out_addr_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_rom_addr_nxt  = r_rom_addr;
    w_remaining_nxt = r_remaining;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_addr_nxt  = r_out_addr;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (bus.burst_len != '0) begin
            w_state_nxt     = FETCH;
            w_rom_addr_nxt  = bus.base_addr;
            w_remaining_nxt = bus.burst_len;
            w_busy_nxt      = 1'b1;
          end else begin
            // Empty burst completes immediately without ever going busy.
            w_done_nxt = 1'b1;
          end
        end
      end

      FETCH: begin
        if (w_load) begin
          w_out_data_nxt  = bus.rom_data;
          w_out_addr_nxt  = r_rom_addr;
          w_out_valid_nxt = 1'b1;
          // Natural overflow wraps the address at the top of the ROM.
          w_rom_addr_nxt  = r_rom_addr + 1'b1;
          w_remaining_nxt = r_remaining - 1'b1;
          if (r_remaining == LEN_WIDTH'(1)) begin
            w_state_nxt = DRAIN;
          end
        end
      end

      DRAIN: begin
        // Wait for the last beat to be taken before reporting completion.
        if (r_out_valid && bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_busy_nxt      = 1'b0;
          w_done_nxt      = 1'b1;
          w_state_nxt     = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.rom_addr  = r_rom_addr;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_addr  = r_out_addr;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rom_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_burst_reader
// Purpose  : Directed self-checking bench for rom_burst_reader. A ROM model
//            returning addr ^ 8'hA5 is wired combinationally to rom_addr.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_burst_reader;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rom_burst_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .LEN_WIDTH(9)) bus ();

  assign bus.rom_data = bus.rom_addr ^ 8'hA5;

  rom_burst_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .LEN_WIDTH(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Advance one clock; returns 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start pulse; returns just after the accepting edge (T+1).
  task automatic do_start(input logic [7:0] base, input logic [8:0] len);
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.burst_len = len;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) tick();
    bus.start = 1'b1; bus.base_addr = 8'h05; bus.burst_len = 9'd3;
    tick();
    rst = 1'b0; bus.start = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", bus.out_data); end
    checks++; if (bus.out_addr !== 8'h00) begin errors++; $display("FAIL reset_out_addr: got %h expected 00", bus.out_addr); end
    checks++; if (bus.rom_addr !== 8'h00) begin errors++; $display("FAIL reset_rom_addr: got %h expected 00", bus.rom_addr); end
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_start_ignored: got busy=%b valid=%b expected 0 0", bus.busy, bus.out_valid); end
  endtask

  task automatic test_basic();
    logic [7:0] ea;
    bus.out_ready = 1'b1;
    do_start(8'h10, 9'd4);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_t1: got %b expected 1", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_t1: got %b expected 0", bus.out_valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      ea = 8'h10 + 8'(i);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid beat %0d: got %b expected 1", i, bus.out_valid); end
      checks++; if (bus.out_addr !== ea) begin errors++; $display("FAIL basic_addr beat %0d: got %h expected %h", i, bus.out_addr, ea); end
      checks++; if (bus.out_data !== (ea ^ 8'hA5)) begin errors++; $display("FAIL basic_data beat %0d: got %h expected %h", i, bus.out_data, ea ^ 8'hA5); end
      checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL basic_status beat %0d: got busy=%b done=%b expected 1 0", i, bus.busy, bus.done); end
    end
    tick();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", bus.done); end
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_end: got busy=%b valid=%b expected 0 0", bus.busy, bus.out_valid); end
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", bus.done); end
  endtask

  task automatic test_backpressure();
    logic       pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] ea, hold_d, hold_a;
    logic       stall = 1'b0;
    logic       got_done = 1'b0;
    int         hs = 0;
    bus.out_ready = pat[0];
    do_start(8'h10, 9'd4);
    for (int cyc = 1; cyc < 60 && !got_done; cyc++) begin
      if (stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== hold_d || bus.out_addr !== hold_a) begin
          errors++;
          $display("FAIL bp_stall_stable: got v=%b d=%h a=%h expected 1 %h %h", bus.out_valid, bus.out_data, bus.out_addr, hold_d, hold_a);
        end
      end
      if (bus.done) begin
        got_done = 1'b1;
        checks++; if (hs != 4) begin errors++; $display("FAIL bp_done_early: got %0d handshakes expected 4", hs); end
      end else begin
        bus.out_ready = pat[cyc % 6];
        if (bus.out_valid && bus.out_ready) begin
          ea = 8'h10 + 8'(hs);
          checks++;
          if (bus.out_addr !== ea || bus.out_data !== (ea ^ 8'hA5)) begin
            errors++;
            $display("FAIL bp_beat %0d: got a=%h d=%h expected a=%h d=%h", hs, bus.out_addr, bus.out_data, ea, ea ^ 8'hA5);
          end
          hs++;
        end
        stall  = bus.out_valid && !bus.out_ready;
        hold_d = bus.out_data;
        hold_a = bus.out_addr;
        tick();
      end
    end
    checks++; if (!got_done) begin errors++; $display("FAIL bp_timeout: got no done expected done"); end
    checks++; if (hs != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", hs); end
    bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    logic [7:0] exp_a [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    logic [7:0] exp_d [4] = '{8'h5B, 8'h5A, 8'hA5, 8'hA4};
    bus.out_ready = 1'b1;
    do_start(8'hFE, 9'd4);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_addr !== exp_a[i] || bus.out_data !== exp_d[i]) begin
        errors++;
        $display("FAIL wrap beat %0d: got v=%b a=%h d=%h expected 1 %h %h", i, bus.out_valid, bus.out_addr, bus.out_data, exp_a[i], exp_d[i]);
      end
    end
    tick();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b expected 1", bus.done); end
    checks++; if (bus.rom_addr !== 8'h02) begin errors++; $display("FAIL wrap_rom_addr_hold: got %h expected 02", bus.rom_addr); end
    tick();
  endtask

  task automatic test_zero_len();
    bus.out_ready = 1'b1;
    do_start(8'h07, 9'd0);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", bus.done); end
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL zero_idle: got busy=%b valid=%b expected 0 0", bus.busy, bus.out_valid); end
    tick();
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL zero_after: got done=%b busy=%b valid=%b expected 0 0 0", bus.done, bus.busy, bus.out_valid); end
  endtask

  task automatic test_full();
    int         beats = 0;
    logic       got_done = 1'b0;
    logic [7:0] ea;
    bus.out_ready = 1'b1;
    do_start(8'h00, 9'd256);
    for (int n = 0; n < 300 && !got_done; n++) begin
      tick();
      if (bus.done) begin
        got_done = 1'b1;
      end else if (bus.out_valid) begin
        ea = 8'(beats);
        checks++;
        if (bus.out_addr !== ea || bus.out_data !== (ea ^ 8'hA5)) begin
          errors++;
          $display("FAIL full beat %0d: got a=%h d=%h expected a=%h d=%h", beats, bus.out_addr, bus.out_data, ea, ea ^ 8'hA5);
        end
        beats++;
      end
    end
    checks++; if (!got_done) begin errors++; $display("FAIL full_timeout: got no done expected done"); end
    checks++; if (beats != 256) begin errors++; $display("FAIL full_count: got %0d expected 256", beats); end
    tick();
  endtask

  task automatic test_restart_ignored();
    bus.out_ready = 1'b1;
    do_start(8'h20, 9'd3);
    tick();
    checks++; if (bus.out_addr !== 8'h20) begin errors++; $display("FAIL restart_beat0: got %h expected 20", bus.out_addr); end
    bus.start = 1'b1; bus.base_addr = 8'h80; bus.burst_len = 9'd5;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.out_addr !== 8'h21) begin errors++; $display("FAIL restart_beat1: got %h expected 21", bus.out_addr); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_addr !== 8'h22) begin errors++; $display("FAIL restart_beat2: got v=%b a=%h expected 1 22", bus.out_valid, bus.out_addr); end
    tick();
    checks++; if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL restart_done: got done=%b valid=%b expected 1 0", bus.done, bus.out_valid); end
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL restart_idle: got busy=%b valid=%b expected 0 0", bus.busy, bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    do_start(8'h40, 9'd5);
    tick();
    tick();
    checks++; if (bus.out_addr !== 8'h41) begin errors++; $display("FAIL rstmid_beat1: got %h expected 41", bus.out_addr); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_clear: got v=%b done=%b busy=%b expected 0 0 0", bus.out_valid, bus.done, bus.busy); end
    checks++; if (bus.rom_addr !== 8'h00) begin errors++; $display("FAIL rstmid_rom_addr: got %h expected 00", bus.rom_addr); end
    tick();
    checks++; if (bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_done: got done=%b v=%b expected 0 0", bus.done, bus.out_valid); end
    do_start(8'h30, 9'd2);
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_addr !== 8'h30 || bus.out_data !== 8'h95) begin errors++; $display("FAIL rstmid_new0: got v=%b a=%h d=%h expected 1 30 95", bus.out_valid, bus.out_addr, bus.out_data); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_addr !== 8'h31 || bus.out_data !== 8'h94) begin errors++; $display("FAIL rstmid_new1: got v=%b a=%h d=%h expected 1 31 94", bus.out_valid, bus.out_addr, bus.out_data); end
    tick();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL rstmid_new_done: got %b expected 1", bus.done); end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    do_start(8'h50, 9'd2);
    tick();
    tick();
    tick();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done1: got %b expected 1", bus.done); end
    do_start(8'h60, 9'd1);
    checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL b2b_accept: got busy=%b done=%b expected 1 0", bus.busy, bus.done); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_addr !== 8'h60 || bus.out_data !== 8'hC5) begin errors++; $display("FAIL b2b_beat: got v=%b a=%h d=%h expected 1 60 C5", bus.out_valid, bus.out_addr, bus.out_data); end
    tick();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b expected 1", bus.done); end
    tick();
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.burst_len = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_full();
    test_restart_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
